// File: rtl/word_bank_16_if.sv
// Bus bundle for word_bank_16: write port, scan handshake and the bank/select
// outputs that feed mux_16.
interface word_bank_16_if;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [15:0]  wr_data;
    logic         start;
    logic [255:0] bank;
    logic [3:0]   sel;
    logic         sel_valid;
    logic         busy;
    logic         done;
    logic         wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, start,
        input  bank, sel, sel_valid, busy, done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start,
        output bank, sel, sel_valid, busy, done, wr_err
    );
endinterface

// File: rtl/word_bank_16.sv
// word_bank_16: 16x16 register bank with a dwell-timed select sweep for mux_16.
// Optional WORD_BANK_WR_BLOCK_EN: writes during SCAN are dropped and flagged on wr_err.
module word_bank_16_entry (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_we,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);
    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_q <= '0;
        else if (i_we) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

module word_bank_16 #(
    parameter int DWELL = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    word_bank_16_if.slave  bus
);
    localparam int         NUM_WORDS = 16;
    localparam logic [7:0] LAST_CNT  = 8'(DWELL - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_busy, r_done;
    logic        w_wr_ok;
    logic [NUM_WORDS-1:0]       w_we;
    logic [NUM_WORDS-1:0][15:0] w_q;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SCAN;
                    w_sel_nxt   = 4'd0;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_SCAN: begin
                if (r_cnt == LAST_CNT) begin
                    if (r_sel != 4'hF) begin
                        w_sel_nxt = r_sel + 4'd1;
                        w_cnt_nxt = 8'd0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // busy/done are flopped from the next state so every output comes from a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 4'd0;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == S_SCAN);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

`ifdef WORD_BANK_WR_BLOCK_EN
    logic r_wr_err;

    assign w_wr_ok = (r_state != S_SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wr_err <= 1'b0;
        else        r_wr_err <= bus.wr_en && (r_state == S_SCAN);
    end

    assign bus.wr_err = r_wr_err;
`else
    assign w_wr_ok    = 1'b1;
    assign bus.wr_err = 1'b0;
`endif

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        assign w_we[k] = bus.wr_en && w_wr_ok && (bus.wr_addr == 4'(k));

        word_bank_16_entry u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .i_we  (w_we[k]),
            .i_d   (bus.wr_data),
            .o_q   (w_q[k])
        );
    end

    assign bus.bank      = w_q;
    assign bus.sel       = r_sel;
    assign bus.sel_valid = r_busy;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_word_bank_16.sv
module tb_word_bank_16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_bank_16_if a_if ();
  word_bank_16_if b_if ();

  word_bank_16 #(.DWELL(10)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  word_bank_16 #(.DWELL(1))  u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  logic [15:0] out_a;
  assign out_a = a_if.bank[{a_if.sel, 4'b0000} +: 16];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem [16];
  logic [3:0]  sel_q [$];
  bit          exp_err = 1'b0;
  int          done_a = 0;
  int          done_b = 0;

  always @(posedge clk) begin
    if (a_if.done === 1'b1) done_a++;
    if (b_if.done === 1'b1) done_b++;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $error("FAIL timeout: bench did not complete within wait limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [255:0] pack_mem();
    logic [255:0] p;
    for (int k = 0; k < 16; k++) p[16*k +: 16] = mem[k];
    return p;
  endfunction

  task automatic wr_a(input logic [3:0] a, input logic [15:0] d);
    a_if.wr_en   = 1'b1;
    a_if.wr_addr = a;
    a_if.wr_data = d;
    @(negedge clk);
    a_if.wr_en = 1'b0;
    mem[a] = d;
  endtask

  task automatic scan_a(input int start_at, input int wr_at, input bit start_in_done);
    logic [3:0] es;
    for (int s = 0; s < 16; s++)
      for (int d = 0; d < 10; d++) sel_q.push_back(4'(s));
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    for (int i = 0; i < 160; i++) begin
      if (sel_q.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL a_queue_empty");
        es = 4'd0;
      end else begin
        es = sel_q.pop_front();
      end
      n_tests++; if (a_if.sel !== es) begin n_fail++; $error("FAIL a_sel observed=%0h expected=%0h", a_if.sel, es); end
      n_tests++; if (a_if.busy !== 1'b1) begin n_fail++; $error("FAIL a_busy observed=%0h", a_if.busy); end
      n_tests++; if (a_if.sel_valid !== 1'b1) begin n_fail++; $error("FAIL a_sel_valid observed=%0h", a_if.sel_valid); end
      n_tests++; if (a_if.done !== 1'b0) begin n_fail++; $error("FAIL a_done_low observed=%0h", a_if.done); end
      n_tests++; if (out_a !== mem[es]) begin n_fail++; $error("FAIL a_out observed=%0h expected=%0h", out_a, mem[es]); end
      n_tests++; if (a_if.wr_err !== exp_err) begin n_fail++; $error("FAIL a_wr_err observed=%0h expected=%0h", a_if.wr_err, exp_err); end
      exp_err = 1'b0;
      if (i == start_at) a_if.start = 1'b1;
      if (i == wr_at) begin
        a_if.wr_en   = 1'b1;
        a_if.wr_addr = es;
        a_if.wr_data = 16'hBEEF;
      end
      @(negedge clk);
      a_if.start = 1'b0;
      a_if.wr_en = 1'b0;
      if (i == wr_at) begin
`ifdef WORD_BANK_WR_BLOCK_EN
        exp_err = 1'b1;
`else
        mem[es] = 16'hBEEF;
`endif
      end
    end
    n_tests++; if (a_if.done !== 1'b1) begin n_fail++; $error("FAIL a_done_pulse observed=%0h", a_if.done); end
    n_tests++; if (a_if.busy !== 1'b0) begin n_fail++; $error("FAIL a_busy_done observed=%0h", a_if.busy); end
    n_tests++; if (a_if.sel !== 4'hF) begin n_fail++; $error("FAIL a_sel_done observed=%0h", a_if.sel); end
    n_tests++; if (a_if.sel_valid !== 1'b0) begin n_fail++; $error("FAIL a_sel_valid_done observed=%0h", a_if.sel_valid); end
    if (start_in_done) a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    n_tests++; if (a_if.done !== 1'b0) begin n_fail++; $error("FAIL a_done_one_cycle observed=%0h", a_if.done); end
    n_tests++; if (a_if.busy !== 1'b0) begin n_fail++; $error("FAIL a_idle_after_done observed=%0h", a_if.busy); end
    n_tests++; if (a_if.sel !== 4'hF) begin n_fail++; $error("FAIL a_sel_hold observed=%0h", a_if.sel); end
  endtask

  initial begin
    logic [3:0] es;
    int         d0;
    a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.start = 1'b0;
    b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0; b_if.start = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = 16'h0000;

    #3;
    n_tests++; if (a_if.bank !== 256'h0) begin n_fail++; $error("FAIL rst_bank observed=%0h", a_if.bank); end
    n_tests++; if (a_if.sel !== 4'h0) begin n_fail++; $error("FAIL rst_sel observed=%0h", a_if.sel); end
    n_tests++; if (a_if.busy !== 1'b0) begin n_fail++; $error("FAIL rst_busy observed=%0h", a_if.busy); end
    n_tests++; if (a_if.done !== 1'b0) begin n_fail++; $error("FAIL rst_done observed=%0h", a_if.done); end
    n_tests++; if (a_if.sel_valid !== 1'b0) begin n_fail++; $error("FAIL rst_sel_valid observed=%0h", a_if.sel_valid); end
    n_tests++; if (a_if.wr_err !== 1'b0) begin n_fail++; $error("FAIL rst_wr_err observed=%0h", a_if.wr_err); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    wr_a(4'd3, 16'h0303);
    n_tests++; if (a_if.bank !== pack_mem()) begin n_fail++; $error("FAIL wr_single observed=%0h", a_if.bank); end
    for (int k = 0; k < 16; k++) wr_a(4'(k), 16'(k * 16'h0101));
    n_tests++; if (a_if.bank !== pack_mem()) begin n_fail++; $error("FAIL wr_all observed=%0h", a_if.bank); end

    scan_a(-1, -1, 1'b0);
    scan_a(50, -1, 1'b1);
    scan_a(-1, 72, 1'b0);
    n_tests++; if (a_if.bank !== pack_mem()) begin n_fail++; $error("FAIL a_bank_after_scans observed=%0h", a_if.bank); end
    n_tests++; if (done_a !== 3) begin n_fail++; $error("FAIL a_done_count observed=%0d", done_a); end

    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    for (int i = 0; i < 93; i++) @(negedge clk);
    n_tests++; if (a_if.sel !== 4'd9) begin n_fail++; $error("FAIL mid_sel9 observed=%0h", a_if.sel); end
    d0 = done_a;
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (a_if.busy !== 1'b0) begin n_fail++; $error("FAIL async_busy observed=%0h", a_if.busy); end
    n_tests++; if (a_if.sel !== 4'd0) begin n_fail++; $error("FAIL async_sel observed=%0h", a_if.sel); end
    n_tests++; if (a_if.bank !== 256'h0) begin n_fail++; $error("FAIL async_bank observed=%0h", a_if.bank); end
    n_tests++; if (a_if.sel_valid !== 1'b0) begin n_fail++; $error("FAIL async_sel_valid observed=%0h", a_if.sel_valid); end
    for (int k = 0; k < 16; k++) mem[k] = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    n_tests++; if (done_a !== d0) begin n_fail++; $error("FAIL no_done_after_rst observed=%0d expected=%0d", done_a, d0); end
    n_tests++; if (a_if.busy !== 1'b0) begin n_fail++; $error("FAIL idle_after_rst observed=%0h", a_if.busy); end

    d0 = done_b;
    for (int s = 0; s < 16; s++) sel_q.push_back(4'(s));
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sel_q.size() == 0) begin
        n_tests++; n_fail++;
        $error("FAIL b_queue_empty");
        es = 4'd0;
      end else begin
        es = sel_q.pop_front();
      end
      n_tests++; if (b_if.sel !== es) begin n_fail++; $error("FAIL b_sel observed=%0h expected=%0h", b_if.sel, es); end
      n_tests++; if (b_if.busy !== 1'b1) begin n_fail++; $error("FAIL b_busy observed=%0h", b_if.busy); end
      n_tests++; if (b_if.done !== 1'b0) begin n_fail++; $error("FAIL b_done_low observed=%0h", b_if.done); end
      @(negedge clk);
    end
    n_tests++; if (b_if.done !== 1'b1) begin n_fail++; $error("FAIL b_done_pulse observed=%0h", b_if.done); end
    n_tests++; if (b_if.busy !== 1'b0) begin n_fail++; $error("FAIL b_busy_done observed=%0h", b_if.busy); end
    @(negedge clk);
    n_tests++; if (b_if.done !== 1'b0) begin n_fail++; $error("FAIL b_done_one_cycle observed=%0h", b_if.done); end
    n_tests++; if (done_b !== d0 + 1) begin n_fail++; $error("FAIL b_done_count observed=%0d expected=%0d", done_b, d0 + 1); end

    if (n_fail != 0) $error("FAIL summary: %0d of %0d checks failed", n_fail, n_tests);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
